// File: rtl/cern_io_pad_link_ctrl.sv
// cern_io_pad_link_ctrl: half-duplex single-wire serial link controller driving one bidirectional IO pad
module cern_io_pad_link_ctrl #(
   parameter int DATA_W     = 8,
   parameter int BIT_DIV    = 4,
   parameter int TURN_CYC   = 2,
   parameter int RX_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              rx_req,
   output logic              ready,
   input  logic              cfg_ds,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_err,
   output logic              rx_timeout,
   output logic              pad_a,
   output logic              pad_out_en,
   output logic              pad_ds,
   output logic              pad_pen,
   output logic              pad_ud_b,
   input  logic              pad_z
);
   localparam int DIV_W = $clog2(BIT_DIV);
   localparam int BIT_W = $clog2(DATA_W + 2);
   localparam int TMO_W = $clog2(RX_TIMEOUT + 1);
   localparam int TRN_W = $clog2(TURN_CYC + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2 - 1);
   localparam logic [BIT_W-1:0] TX_LAST  = BIT_W'(DATA_W + 1);
   localparam logic [BIT_W-1:0] RX_STOP  = BIT_W'(DATA_W);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(RX_TIMEOUT);
   localparam logic [TRN_W-1:0] TRN_LAST = TRN_W'(TURN_CYC - 1);

   typedef enum logic [2:0] {IDLE, TX_BIT, TURN, RX_WAIT, RX_START, RX_BIT} state_t;

   state_t            state;
   logic              z_s1, z_s2;
   logic [DIV_W-1:0]  div;
   logic [BIT_W-1:0]  bit_cnt;
   logic [TMO_W-1:0]  tmo;
   logic [TRN_W-1:0]  turn_cnt;
   logic [DATA_W:0]   tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic              div_done, tmo_hit;
   logic [TMO_W-1:0]  tmo_next;

   assign div_done = div == DIV_LAST;
   assign tmo_hit  = tmo == TMO_MAX;
   assign tmo_next = tmo_hit ? tmo : tmo + TMO_W'(1);
   assign pad_ud_b = 1'b1;

   // two-flop synchroniser for the asynchronous pad input, idling high like the pulled-up line
   always_ff @(posedge clk) begin
      if (rst) begin
         z_s1 <= 1'b1;
         z_s2 <= 1'b1;
      end else begin
         z_s1 <= pad_z;
         z_s2 <= z_s1;
      end
   end

   // link sequencer: TX serialisation, bus turnaround, start search and RX deserialisation with registered pad controls
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ready      <= 1'b0;
         pad_out_en <= 1'b0;
         pad_a      <= 1'b1;
         pad_pen    <= 1'b1;
         pad_ds     <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_err     <= 1'b0;
         rx_timeout <= 1'b0;
         div        <= '0;
         bit_cnt    <= '0;
         tmo        <= '0;
         turn_cnt   <= '0;
         tx_sh      <= '0;
         rx_sh      <= '0;
      end else begin
         rx_valid   <= 1'b0;
         rx_err     <= 1'b0;
         rx_timeout <= 1'b0;
         case (state)
            IDLE: begin
               ready <= 1'b1;
               if (ready && tx_valid) begin
                  state      <= TX_BIT;
                  ready      <= 1'b0;
                  pad_ds     <= cfg_ds;
                  tx_sh      <= {tx_data, 1'b1};
                  pad_a      <= 1'b0;
                  pad_out_en <= 1'b1;
                  pad_pen    <= 1'b0;
                  div        <= '0;
                  bit_cnt    <= '0;
               end else if (ready && rx_req) begin
                  state    <= TURN;
                  ready    <= 1'b0;
                  pad_ds   <= cfg_ds;
                  turn_cnt <= '0;
               end
            end
            TX_BIT: begin
               div <= div_done ? '0 : div + DIV_W'(1);
               if (div_done) begin
                  if (bit_cnt == TX_LAST) begin
                     state      <= IDLE;
                     ready      <= 1'b1;
                     pad_out_en <= 1'b0;
                     pad_pen    <= 1'b1;
                     pad_a      <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     pad_a   <= tx_sh[DATA_W];
                     tx_sh   <= {tx_sh[DATA_W-1:0], 1'b1};
                  end
               end
            end
            TURN: begin
               turn_cnt <= turn_cnt + TRN_W'(1);
               if (turn_cnt == TRN_LAST) begin
                  state <= RX_WAIT;
                  tmo   <= '0;
               end
            end
            RX_WAIT: begin
               tmo <= tmo_next;
               div <= '0;
               if (tmo_hit) begin
                  state      <= IDLE;
                  ready      <= 1'b1;
                  rx_err     <= 1'b1;
                  rx_timeout <= 1'b1;
               end else if (!z_s2) begin
                  state <= RX_START;
               end
            end
            RX_START: begin
               tmo <= tmo_next;
               div <= (div == DIV_HALF) ? '0 : div + DIV_W'(1);
               if (div == DIV_HALF) begin
                  bit_cnt <= '0;
                  state   <= z_s2 ? RX_WAIT : RX_BIT;
               end
            end
            RX_BIT: begin
               div <= div_done ? '0 : div + DIV_W'(1);
               if (div_done) begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  rx_sh   <= (rx_sh << 1) | DATA_W'(z_s2);
                  if (bit_cnt == RX_STOP) begin
                     state    <= IDLE;
                     ready    <= 1'b1;
                     rx_data  <= rx_sh;
                     rx_valid <= z_s2;
                     rx_err   <= !z_s2;
                  end
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cern_io_pad_link_ctrl.sv
// tb_cern_io_pad_link_ctrl: randomized scoreboard bench for the pad link controller
module tb_cern_io_pad_link_ctrl;
   localparam int DATA_W     = 8;
   localparam int BIT_DIV    = 4;
   localparam int TURN_CYC   = 2;
   localparam int RX_TIMEOUT = 64;
   localparam int FRAME_CYC  = (DATA_W + 2) * BIT_DIV;

   typedef enum int {EV_TX, EV_RX_OK, EV_RX_BAD, EV_TMO} ev_kind_t;
   typedef struct {
      ev_kind_t          kind;
      logic [DATA_W-1:0] data;
      logic              ds;
      longint            at;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_valid = 1'b0;
   logic rx_req = 1'b0;
   logic cfg_ds = 1'b0;
   logic pad_z = 1'b1;
   logic [DATA_W-1:0] tx_data = '0;
   logic ready, rx_valid, rx_err, rx_timeout, pad_a, pad_out_en, pad_ds, pad_pen, pad_ud_b;
   logic [DATA_W-1:0] rx_data;

   ev_t    exp_q[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   logic [DATA_W-1:0] model_rx = '0;
   logic [DATA_W-1:0] rd;
   logic col, pen_ok, ds_ok, ds_first, ok, r;
   logic a_bits[$];
   int   n;

   cern_io_pad_link_ctrl #(
      .DATA_W(DATA_W), .BIT_DIV(BIT_DIV), .TURN_CYC(TURN_CYC), .RX_TIMEOUT(RX_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .rx_req(rx_req),
      .ready(ready), .cfg_ds(cfg_ds), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .rx_timeout(rx_timeout), .pad_a(pad_a), .pad_out_en(pad_out_en), .pad_ds(pad_ds),
      .pad_pen(pad_pen), .pad_ud_b(pad_ud_b), .pad_z(pad_z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endfunction

   // line level during frame bit idx: start 0, data MSB first, stop 1
   function automatic logic frame_bit(input logic [DATA_W-1:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx > DATA_W) return 1'b1;
      return d[DATA_W-idx];
   endfunction

   function automatic void push_tx(input logic [DATA_W-1:0] d, input logic ds);
      ev_t e;
      e.kind = EV_TX;
      e.data = d;
      e.ds   = ds;
      e.at   = -1;
      exp_q.push_back(e);
   endfunction

   // monitor: collects driven frames and reply pulses and pops the scoreboard
   initial begin
      ev_t ev;
      int bad;
      col = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            col = 1'b0;
            if (rx_valid || rx_err) check("pulse_in_rst", {rx_valid, rx_err}, 0);
         end else begin
            if (rx_valid && rx_err) check("pulse_both", rx_valid & rx_err, 0);
            if (pad_out_en && (rx_valid || rx_err)) check("pulse_in_tx", {rx_valid, rx_err}, 0);
            if (pad_out_en) begin
               if (!col) begin
                  col = 1'b1;
                  a_bits.delete();
                  pen_ok = 1'b1;
                  ds_ok = 1'b1;
                  ds_first = pad_ds;
               end
               a_bits.push_back(pad_a);
               pen_ok &= !pad_pen;
               ds_ok &= (pad_ds == ds_first);
            end else if (col) begin
               col = 1'b0;
               check("tx_release", {pad_a, pad_pen}, 2'b11);
               if (exp_q.size() == 0 || exp_q[0].kind != EV_TX) begin
                  check("tx_unexpected", a_bits.size(), 0);
               end else begin
                  ev = exp_q.pop_front();
                  bad = 0;
                  for (int i = 0; i < a_bits.size(); i++)
                     if (a_bits[i] !== frame_bit(ev.data, i / BIT_DIV)) bad++;
                  check("tx_len", a_bits.size(), FRAME_CYC);
                  check("tx_wave_errs", bad, 0);
                  check("tx_pen_low", pen_ok, 1);
                  check("tx_ds", {ds_ok, ds_first}, {1'b1, ev.ds});
               end
            end
            if (rx_valid || rx_err) begin
               if (exp_q.size() == 0 || exp_q[0].kind == EV_TX) begin
                  check("rx_unexpected", {rx_valid, rx_err}, 0);
               end else begin
                  ev = exp_q.pop_front();
                  check("rx_kind", rx_valid ? EV_RX_OK : (rx_timeout ? EV_TMO : EV_RX_BAD), ev.kind);
                  check("rx_data", rx_data, ev.data);
                  if (ev.at >= 0) check("rx_time", cyc, ev.at);
               end
            end
         end
      end
   end

   task automatic wait_ready(output logic got);
      int k = 0;
      @(negedge clk);
      while (!ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      got = ready;
      if (!ready) check("ready_wait", ready, 1);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         check("drain_pending", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic do_tx(input logic [DATA_W-1:0] d, input logic ds);
      logic g;
      wait_ready(g);
      if (!g) return;
      tx_valid = 1'b1;
      tx_data = d;
      cfg_ds = ds;
      push_tx(d, ds);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data = DATA_W'($urandom);
      cfg_ds = ~ds;
      drain();
   endtask

   // after RX acceptance at cycle acc: expect the reply and drive it (or nothing)
   task automatic rx_frame(input longint acc, input logic [DATA_W-1:0] d, input logic stop,
                           input int dly, input logic glitch, input logic none);
      ev_t e;
      logic [DATA_W+1:0] fr;
      e.ds   = 1'b0;
      e.data = none ? model_rx : d;
      e.kind = none ? EV_TMO : (stop ? EV_RX_OK : EV_RX_BAD);
      e.at   = none ? acc + TURN_CYC + RX_TIMEOUT + 1 : -1;
      if (!none) model_rx = d;
      exp_q.push_back(e);
      if (!none) begin
         repeat (TURN_CYC + dly) @(posedge clk);
         #1;
         if (glitch) begin
            pad_z = 1'b0;
            @(posedge clk);
            #1;
            pad_z = 1'b1;
            repeat (6) @(posedge clk);
            #1;
         end
         fr = {1'b0, d, stop};
         for (int i = DATA_W + 1; i >= 0; i--) begin
            pad_z = fr[i];
            repeat (BIT_DIV) @(posedge clk);
            #1;
         end
         pad_z = 1'b1;
      end
      drain();
   endtask

   task automatic do_rx(input logic [DATA_W-1:0] d, input logic stop, input int dly,
                        input logic glitch, input logic none);
      logic g;
      wait_ready(g);
      if (!g) return;
      rx_req = 1'b1;
      cfg_ds = 1'($urandom);
      @(posedge clk);
      #1;
      rx_req = 1'b0;
      rx_frame(cyc, d, stop, dly, glitch, none);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t reached without finishing", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 0);
      check("rst_out_en", pad_out_en, 0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("idle_ready", ready, 1);
      check("idle_pads", {pad_out_en, pad_pen, pad_ud_b, pad_a, pad_ds}, 5'b01110);
      check("idle_rx", {rx_data, rx_valid, rx_err, rx_timeout}, 0);

      do_tx(8'hA5, 1'b1);
      do_rx(8'h3C, 1'b1, 5, 1'b0, 1'b0);
      do_rx(8'h00, 1'b0, 0, 1'b0, 1'b1);
      do_rx(8'h81, 1'b0, 3, 1'b1, 1'b0);

      // simultaneous requests: TX first, held rx_req accepted afterwards
      wait_ready(ok);
      tx_valid = 1'b1;
      rx_req = 1'b1;
      tx_data = 8'h5A;
      cfg_ds = 1'b0;
      push_tx(8'h5A, 1'b0);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         r = ready;
         @(posedge clk);
         n++;
      end while (!r && n < 200);
      #1;
      rx_req = 1'b0;
      check("rx_accept", r, 1);
      check("rx_after_tx", exp_q.size(), 0);
      rx_frame(cyc, 8'hC3, 1'b1, 2, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rd = DATA_W'($urandom);
         case ($urandom_range(0, 4))
            0, 1: do_tx(rd, 1'($urandom));
            2: do_rx(rd, 1'b1, $urandom_range(1, 8), 1'($urandom), 1'b0);
            3: do_rx(rd, 1'b0, $urandom_range(1, 8), 1'($urandom), 1'b0);
            default: do_rx(rd, 1'b0, 0, 1'b0, 1'b1);
         endcase
      end

      // reset in the middle of a transmission
      wait_ready(ok);
      tx_valid = 1'b1;
      tx_data = 8'h00;
      cfg_ds = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("tx_running", pad_out_en, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_pads", {pad_out_en, pad_pen, pad_a, pad_ds}, 4'b0110);
      check("rst_mid_ready", ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      do_tx(8'h3E, 1'b0);
      do_rx(8'h99, 1'b1, 4, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
